line_data_memory: RTL

LINE_DATA_MEMORY -- requirements
Module: line_data_memory

---
 rtl/line_data_memory_pkg.sv | 20 ++
 rtl/line_data_memory_array.sv | 41 ++++
 rtl/line_data_memory.sv | 116 +++++++++++
 3 files changed

// File: rtl/line_data_memory_pkg.sv
// Shared definitions for the line data memory: line geometry, latency
// counter width and the request-sequencing state encoding.
package line_data_memory_pkg;

    localparam int LINE_W   = 256;  // bits per cache line
    localparam int OFFSET_W = 5;    // byte-offset bits inside a line
    localparam int CNT_W    = 8;    // latency counter width (LATENCY <= 255)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Value loaded into the latency counter at capture time.
    function automatic logic [CNT_W-1:0] latency_load(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/line_data_memory_array.sv
// Line storage: DEPTH x 256-bit array with one synchronous write port and
// one synchronous read port whose output register holds the last read line.
module data_memory_array
    import line_data_memory_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [LINE_W-1:0]        i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [LINE_W-1:0]        o_rdata
);

    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rdata;

    // Write port: store a full line on a write completion.
    // NOTE: the array itself has no reset so it can map onto RAM macros and keeps
    // its contents across a reset; only the small read register below is reset.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: load the output register only on a read completion, else hold.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/line_data_memory.sv
// Fixed-latency line memory for a cache controller. A request is captured in
// IDLE, waits LATENCY cycles in BUSY, completes on the BUSY->ACK edge and
// signals completion with a one-cycle ack_o pulse in ACK.
module line_data_memory
    import line_data_memory_pkg::*;
#(
    parameter int LATENCY = 10,   // 1..255
    parameter int DEPTH   = 512   // power of two, >= 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_capture;
    logic               w_complete;

    logic               r_write;
    logic [IDX_W-1:0]   r_idx;
    logic [LINE_W-1:0]  r_wdata;

    logic [IDX_W-1:0]   w_idx;
    logic               w_we;
    logic               w_re;
    logic               w_unused_addr;

    // Line index; upper bits alias and the byte offset is dropped.
    assign w_idx         = addr_i[IDX_W+OFFSET_W-1:OFFSET_W];
    assign w_unused_addr = ^{addr_i[31:IDX_W+OFFSET_W], addr_i[OFFSET_W-1:0]};

    // State and latency counter registers; reset aborts any request in flight.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and ack decode.
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_complete  = 1'b0;
        ack_o       = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable_i) begin
                    w_capture   = 1'b1;
                    w_cnt_nxt   = latency_load(LATENCY);
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ACK: begin
                ack_o       = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request capture; these registers are only consumed after a capture, so
    // they need no reset.
    always_ff @(posedge clk_i) begin
        if (w_capture) begin
            r_write <= write_i;
            r_idx   <= w_idx;
            r_wdata <= data_i;
        end
    end

    assign w_we = w_complete &  r_write;
    assign w_re = w_complete & ~r_write;

    data_memory_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_re    (w_re),
        .i_raddr (r_idx),
        .o_rdata (data_o)
    );

endmodule
